// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: state encoding, special opcodes
// and the bit positions of the decoded control flags.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hE;

    localparam int CF_LDI = 0;
    localparam int CF_RE  = 1;
    localparam int CF_WE  = 2;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane handling for the 16-bit memory word: merges a store byte into
// the addressed lane and selects the addressed byte for loads.
module mem_byte_lane (
    input  logic        lane,
    input  logic [15:0] rdata,
    input  logic [7:0]  wbyte,
    output logic [15:0] wdata,
    output logic [7:0]  rbyte
);

    assign wdata = lane ? {wbyte, rdata[7:0]} : {rdata[15:8], wbyte};
    assign rbyte = lane ? rdata[15:8] : rdata[7:0];

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for a small 16-bit-instruction CPU: drives the
// shared memory port, the register file write port and the program counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W     = 7,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    input  logic            mem_ready,
    input  logic [15:0]     mem_rdata,
    input  logic [2:0]      ctrl_flags,
    input  logic [7:0]      reg_o1,
    input  logic [7:0]      reg_o2,
    input  logic [7:0]      alu_out,
    output logic [7:0]      mem_addr,
    output logic            mem_we,
    output logic [15:0]     mem_wdata,
    output logic [15:0]     inst,
    output logic [PC_W-1:0] pc,
    output logic            reg_we,
    output logic [7:0]      reg_wdata,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     inst_q, inst_d;
    logic [PC_W:0]   fetch_addr;
    logic [7:0]      load_byte;
    logic [3:0]      opcode;
    logic            mem_we_raw, reg_we_raw, done;

    assign opcode     = inst_q[15:12];
    assign fetch_addr = {pc_q, 1'b0};

    always_comb begin
        mem_addr = '0;
        if (state_q == ST_FETCH)     mem_addr = 8'(fetch_addr);
        else if (state_q == ST_EXEC) mem_addr = reg_o1;
    end

    mem_byte_lane u_lane (
        .lane  (mem_addr[0]),
        .rdata (mem_rdata),
        .wbyte (reg_o2),
        .wdata (mem_wdata),
        .rbyte (load_byte)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        mem_we_raw = 1'b0;
        reg_we_raw = 1'b0;
        reg_wdata  = '0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: if (run || step) state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    inst_d  = mem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    done = 1'b1;
                    // Store outranks every other flag; multi-cycle ops wait on mem_ready.
                    if (opcode == OP_JMP) begin
                        pc_d = inst_q[PC_W-1:0];
                    end else if (ctrl_flags[CF_WE]) begin
                        mem_we_raw = 1'b1;
                        done       = mem_ready;
                    end else if (ctrl_flags[CF_LDI]) begin
                        reg_we_raw = 1'b1;
                        reg_wdata  = inst_q[7:0];
                    end else if (ctrl_flags[CF_RE]) begin
                        reg_we_raw = mem_ready;
                        reg_wdata  = load_byte;
                        done       = mem_ready;
                    end else begin
                        reg_we_raw = 1'b1;
                        reg_wdata  = alu_out;
                    end
                    if (done) state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    // Reset aborts an in-flight access, so no write escapes in the reset cycle.
    assign mem_we = mem_we_raw & rst_n;
    assign reg_we = reg_we_raw & rst_n;
    assign inst   = inst_q;
    assign pc     = pc_q;
    assign halted = (state_q == ST_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_W'(RESET_PC);
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PC_W, default 7, word-address width of the program counter.
REQ-002 Parameter RESET_PC, default 0, program counter value after reset.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 run  in  1  level; 1 = execute continuously, 0 = stop at next instruction boundary.
REQ-006 step  in  1  one-cycle pulse; from IDLE executes exactly one instruction.
REQ-007 mem_ready  in  1  memory access completes this cycle.
REQ-008 mem_rdata  in  16  memory read word.
REQ-009 ctrl_flags  in  3  decoded control bits from the instruction ROM: [2] mem_we, [1] mem_re, [0] ldi.
REQ-010 reg_o1, reg_o2, alu_out  in  8 each  register file read ports and ALU result.
REQ-011 mem_addr  out  8  byte address; mem_we  out  1; mem_wdata  out  16.
REQ-012 inst  out  16  instruction register; pc  out  PC_W  program counter.
REQ-013 reg_we  out  1; reg_wdata  out  8  register file write port.
REQ-014 halted  out  1  HALT state reached.

Function
REQ-015 States IDLE, FETCH, EXEC, HALT; exactly one active per cycle.
REQ-016 IDLE: no memory or register write; next FETCH when run=1 or step=1 (both high behaves as run=1).
REQ-017 FETCH: mem_addr={pc,1'b0}, mem_we=0, reg_we=0; when mem_ready=1: inst<=mem_rdata, pc<=pc+1 (wraps from all-ones to 0), next EXEC; otherwise hold FETCH with no state change.
REQ-018 EXEC: mem_addr=reg_o1; opcode is inst[15:12].
REQ-019 Opcode 4'hF (HALT): no writes, next HALT; ctrl_flags ignored.
REQ-020 Opcode 4'hE (JMP): pc<=inst[PC_W-1:0], no writes, completes in one cycle.
REQ-021 Otherwise, priority mem_we > ldi > mem_re > ALU.
REQ-022 Store: mem_we=1 while in EXEC; mem_wdata replaces byte lane mem_addr[0] with reg_o2 and keeps the other lane from mem_rdata; reg_we=0; completes on mem_ready.
REQ-023 Load immediate: reg_we=1, reg_wdata=inst[7:0]; completes in one cycle.
REQ-024 Load: reg_wdata=mem_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]; reg_we=mem_ready; completes on mem_ready, otherwise holds EXEC.
REQ-025 ALU: reg_we=1, reg_wdata=alu_out; completes in one cycle.
REQ-026 On EXEC completion: next FETCH if run=1, else IDLE; a step-started instruction with run=0 returns to IDLE.
REQ-027 reg_we and mem_we never assert in the same cycle, and never outside EXEC.
REQ-028 HALT: halted=1, all writes 0, state held until reset; run and step ignored.
REQ-029 Minimum latency with mem_ready tied high: 2 cycles per instruction (FETCH + EXEC).

Reset
REQ-030 With rst_n=0 at posedge: state=IDLE, pc=RESET_PC, inst=0, halted=0, reg_we=0, mem_we=0.
REQ-031 Reset mid-FETCH or mid-EXEC aborts the access; no write is issued in the reset cycle.

Structure
REQ-032 Shared package cpu_pkg holds the state enum, OP_HALT=4'hF, OP_JMP=4'hE, and the ctrl_flags bit indices.
REQ-033 Byte-lane merge and select logic lives in a sub-module mem_byte_lane; everything else is flat.

Verification
REQ-034 Program LDI r1,10; LDI r2,2; ADD r3,r1,r2 with mem_ready=1 and run=1 from reset: r1=10 after cycle 3, r2=2 after cycle 5, r3=12 after cycle 7.
REQ-035 Store, then load from byte addresses 8'h11 and 8'h10: the stored upper byte reads back, and the lower byte of word 8 is unchanged.
REQ-036 mem_ready held low for 3 cycles during FETCH and during a load: state held, no reg_we, and pc advances exactly once.
REQ-037 JMP to 7'h7F, then execute the instruction there: pc wraps to 0 after that fetch; HALT at 0: halted=1, and run or step has no further effect.
REQ-038 With run=0, a step pulse executes one LDI and returns to IDLE; rst_n=0 asserted mid-EXEC of a store gives mem_we=0 and pc=0.
